truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus and response stage wrapped around a 4-input combinational function block (outputs f from inputs a,b,c,d).
- Upstream role: drives the function block's a,b,c,d with all 2^N_IN input combinations in ascending binary order, each held for HOLD_CYCLES clocks.
- Downstream role: samples the function's f at the end of each hold window and assembles the full truth table plus a minterm count.
- Replaces hand-written exhaustive stimulus blocks with a synthesizable on-chip sweeper.

Parameters:
- N_IN, 4, number of function inputs; the sweep covers 2^N_IN vectors.
- HOLD_CYCLES, 2, clocks each vector is held before f is sampled; legal range is 1 or more.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  single-cycle request to begin a sweep.
- f_in  input  1  output f of the function under sweep.
- vec  output  N_IN  drives function inputs; vec[N_IN-1] is a (MSB), vec[0] is d.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- tt  output  2^N_IN  captured truth table; tt[i] is f for vec==i.
- ones_count  output  N_IN+1  number of 1 bits in tt (minterm count).

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE; vec, tt, ones_count, hold counter and index all 0; busy=0; done=0. Reset overrides everything, including mid-sweep, and any partial table is discarded.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 -> RUN.
  - On entry to RUN: idx=0, hold=0, vec=0, tt=0, ones_count=0, busy=1.
- RUN:
  - Each clock, hold increments.
  - When hold==HOLD_CYCLES-1: tt[idx] <= f_in; ones_count <= ones_count + f_in; hold <= 0.
  - If idx==2^N_IN-1, go to DONE. Otherwise idx and vec increment.
  - vec always equals idx while in RUN.
  - start is ignored in RUN.
- DONE:
  - busy=0, done=1; vec holds the last vector; tt and ones_count stay stable.
  - start=1 -> RUN (same entry actions; done drops in the same cycle busy rises).
- Timing:
  - start is accepted at edge k; vector 0 appears after edge k.
  - Each vector is driven for exactly HOLD_CYCLES clocks.
  - f is sampled on the final edge of each window.
  - done rises after edge k + 2^N_IN*HOLD_CYCLES; default total is 32 clocks.
- HOLD_CYCLES=1: sample every clock; f must settle within one cycle.
- Width rules:
  - idx is N_IN bits and never wraps inside RUN; the terminal index ends the sweep.
  - ones_count cannot overflow; its maximum is 2^N_IN.
- start held high across DONE->RUN->DONE: a new sweep begins only on the edge where state is IDLE or DONE.
- busy and done are never both 1.

Decomposition:
- Shared package truth_table_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default N_IN and HOLD_CYCLES values.
- One natural sub-module, hold_timer: a HOLD_CYCLES-modulo counter with a clear input and a wrap pulse output. It supplies the sample/advance strobe to the FSM.
- The FSM, index register, truth-table capture and ones_count stay in the top module.

Test Plan:
- f_in = a^b^c^d (parity model), defaults; pulse start -> vec steps 0..15, two cycles each; done after 32 clocks; tt=16'h6996, ones_count=8.
- f_in = a&b&c&d -> tt=16'h8000, ones_count=1. Then f_in = constant 0 with a restart from DONE -> tt=16'h0000, ones_count=0, with tt cleared at restart.
- HOLD_CYCLES=3, parity model -> each vec held exactly 3 clocks; done after 48 clocks; tt=16'h6996.
- Reset mid-sweep: drop rst_n at vec==7 -> next edge gives vec=0, tt=0, ones_count=0, busy=0, done=0. A fresh start then completes normally.
- Pulse start again while busy at vec==5 -> ignored: no restart, sequence continues, done still after 32 clocks from the original start.
- Hold start high continuously, AND model -> back-to-back sweeps. done is high for exactly one cycle between sweeps, busy and done never overlap, and tt=16'h8000 after each sweep.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// State encoding and default parameter values used by the top and the bench.
package truth_table_pkg;

   localparam int unsigned N_IN_DEF        = 4;
   localparam int unsigned HOLD_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Modulo-HOLD_CYCLES counter; wrap_c marks the last cycle of each hold window.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic wrap_c
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   assign wrap_c = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || wrap_c) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: walks vec through all 2^N_IN codes and captures
// the function response into a truth table with a running minterm count.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int unsigned N_IN        = N_IN_DEF,
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  f_in,
   output logic [N_IN-1:0]       vec,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<N_IN)-1:0]  tt,
   output logic [N_IN:0]         ones_count
);

   localparam int unsigned N_VEC = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [N_VEC-1:0]  tt_d;
   logic [N_IN:0]     ones_d;
   logic              busy_d, done_d;
   logic              hold_clr_c;
   logic              wrap_c;

   // Timer only runs inside a sweep, so every sweep starts with a fresh window.
   assign hold_clr_c = (state_q != ST_RUN);

   hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (hold_clr_c),
      .wrap_c (wrap_c)
   );

   assign vec = idx_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         tt         <= '0;
         ones_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tt         <= tt_d;
         ones_count <= ones_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tt_d    = tt;
      ones_d  = ones_count;
      busy_d  = busy;
      done_d  = done;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               idx_d   = '0;
               tt_d    = '0;
               ones_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         ST_RUN: begin
            // Sample on the final edge of the window, then advance or finish.
            if (wrap_c) begin
               tt_d[idx_q] = f_in;
               ones_d      = ones_count + (N_IN+1)'(f_in);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + N_IN'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (hold 2 and hold 3) checked each
// cycle against a time-based model, plus literal checks on the final tables.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0, start3 = 1'b0;
   logic        f0, f3;
   logic [3:0]  vec0, vec3;
   logic        busy0, busy3, done0, done3;
   logic [15:0] tt0, tt3;
   logic [4:0]  ones0, ones3;
   int          fsel0 = 0, fsel3 = 0;

   int tests = 0;
   int fails = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   // 0: parity, 1: AND of all inputs, other: constant 0
   function automatic logic fn(input int sel, input logic [3:0] v);
      case (sel)
         0:       return ^v;
         1:       return &v;
         default: return 1'b0;
      endcase
   endfunction

   assign f0 = fn(fsel0, vec0);
   assign f3 = fn(fsel3, vec3);

   truth_table_sweeper dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0), .vec(vec0),
      .busy(busy0), .done(done0), .tt(tt0), .ones_count(ones0)
   );

   truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3), .vec(vec3),
      .busy(busy3), .done(done3), .tt(tt3), .ones_count(ones3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time since accepted start decides vector, sample points and end.
   int          hold_of[2] = '{2, 3};
   int          m_t[2];
   logic        m_busy[2], m_done[2];
   logic [15:0] m_tt[2];
   int          m_vec[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin : model_step
         logic st;
         int   sel;
         int   h;
         st  = (i == 0) ? start0 : start3;
         sel = (i == 0) ? fsel0 : fsel3;
         h   = hold_of[i];
         if (!rst_n) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0; m_tt[i] = '0; m_vec[i] = 0;
         end else if (!m_busy[i] && st) begin
            m_busy[i] = 1'b1; m_done[i] = 1'b0; m_t[i] = 0; m_tt[i] = '0; m_vec[i] = 0;
         end else if (m_busy[i]) begin
            m_t[i]++;
            if (m_t[i] % h == 0)
               m_tt[i][m_t[i]/h - 1] = fn(sel, 4'(m_t[i]/h - 1));
            if (m_t[i] == 16*h) begin
               m_busy[i] = 1'b0;
               m_done[i] = 1'b1;
            end else begin
               m_vec[i] = m_t[i] / h;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("vec0",  32'(vec0),  32'(m_vec[0]));
         chk("busy0", 32'(busy0), 32'(m_busy[0]));
         chk("done0", 32'(done0), 32'(m_done[0]));
         chk("tt0",   32'(tt0),   32'(m_tt[0]));
         chk("ones0", 32'(ones0), 32'($countones(m_tt[0])));
         chk("vec3",  32'(vec3),  32'(m_vec[1]));
         chk("busy3", 32'(busy3), 32'(m_busy[1]));
         chk("done3", 32'(done3), 32'(m_done[1]));
         chk("tt3",   32'(tt3),   32'(m_tt[1]));
         chk("ones3", 32'(ones3), 32'($countones(m_tt[1])));
         chk("busy_done_excl", 32'(busy0 & done0 | busy3 & done3), 32'd0);
      end
   end

   task automatic pulse_start(input int inst);
      if (inst == 0) start0 = 1'b1; else start3 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_done(input int inst, output int n);
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if ((inst == 0) ? done0 : done3) break;
         if (n >= 300) begin
            tests++; fails++;
            $display("FAIL done_timeout inst %0d: no done after %0d cycles", inst, n);
            break;
         end
      end
   endtask

   task automatic wait_vec0(input logic [3:0] v);
      int n;
      n = 0;
      while (vec0 != v) begin
         @(negedge clk);
         n++;
         if (n >= 300) begin
            tests++; fails++;
            $display("FAIL vec_timeout: vec0 never reached %0d", v);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int episodes, runlen, cyc;
      bit pulsed;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_vec",  32'(vec0),  32'd0);
      chk("rst_tt",   32'(tt0),   32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Parity sweep, hold 2
      fsel0 = 0;
      pulse_start(0);
      chk("par_first_busy", 32'(busy0), 32'd1);
      wait_done(0, n);
      chk("par_latency", 32'(n), 32'd32);
      chk("par_tt",   32'(tt0),   32'h6996);
      chk("par_ones", 32'(ones0), 32'd8);

      // AND sweep, then constant-0 restart from DONE
      fsel0 = 1;
      pulse_start(0);
      wait_done(0, n);
      chk("and_tt",   32'(tt0),   32'h8000);
      chk("and_ones", 32'(ones0), 32'd1);
      fsel0 = 2;
      pulse_start(0);
      chk("restart_tt_cleared", 32'(tt0), 32'd0);
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_done", 32'(done0), 32'd0);
      wait_done(0, n);
      chk("zero_tt",   32'(tt0),   32'h0000);
      chk("zero_ones", 32'(ones0), 32'd0);

      // Parity sweep, hold 3
      fsel3 = 0;
      pulse_start(3);
      wait_done(3, n);
      chk("h3_latency", 32'(n), 32'd48);
      chk("h3_tt",   32'(tt3),   32'h6996);
      chk("h3_ones", 32'(ones3), 32'd8);

      // Reset mid-sweep at vec==7
      fsel0 = 0;
      pulse_start(0);
      wait_vec0(4'd7);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_vec",  32'(vec0),  32'd0);
      chk("mid_rst_tt",   32'(tt0),   32'd0);
      chk("mid_rst_ones", 32'(ones0), 32'd0);
      chk("mid_rst_busy", 32'(busy0), 32'd0);
      chk("mid_rst_done", 32'(done0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start(0);
      wait_done(0, n);
      chk("post_rst_latency", 32'(n), 32'd32);
      chk("post_rst_tt", 32'(tt0), 32'h6996);

      // start while busy at vec==5 is ignored
      pulse_start(0);
      n = 0;
      pulsed = 1'b0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (start0) start0 = 1'b0;
         if (done0) break;
         if (vec0 == 4'd5 && !pulsed) begin
            start0 = 1'b1;
            pulsed = 1'b1;
         end
      end
      chk("busy_start_latency", 32'(n), 32'd32);
      chk("busy_start_tt", 32'(tt0), 32'h6996);

      // start held high: back-to-back AND sweeps
      fsel0 = 1;
      start0 = 1'b1;
      episodes = 0;
      runlen = 0;
      cyc = 0;
      while (episodes < 3 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done0) begin
            runlen++;
            if (runlen == 1) chk("b2b_tt", 32'(tt0), 32'h8000);
         end else if (runlen > 0) begin
            chk("b2b_done_len", 32'(runlen), 32'd1);
            runlen = 0;
            episodes++;
         end
      end
      start0 = 1'b0;
      chk("b2b_episodes", 32'(episodes), 32'd3);
      repeat (40) @(negedge clk);
      chk("b2b_final_tt", 32'(tt0), 32'h8000);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
